sprite_rom_arbiter: RTL and testbench

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_rom_arbiter_pkg.sv | 23 ++
 rtl/sprite_rom_arbiter_rr.sv | 44 ++++
 rtl/sprite_rom_arbiter.sv | 111 +++++++++++
 tb/tb_sprite_rom_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_rom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_rom_arbiter_pkg
// Purpose  : Shared defaults and tag-pipeline record for the sprite ROM
//            arbiter and its round-robin sub-block.
// Revision : 1.0 - initial release
// ============================================================================
package sprite_rom_arbiter_pkg;

  localparam int SPR_NUM_REQ = 4;
  localparam int SPR_X_W     = 7;
  localparam int SPR_Y_W     = 5;
  localparam int SPR_COLOR_W = 12;
  localparam int SPR_ID_W    = 2;

  // One stage of the response tag pipeline that shadows the ROM latency.
  typedef struct packed {
    logic                valid;
    logic [SPR_ID_W-1:0] id;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/sprite_rom_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. Searches req starting at
//            rr_ptr, wrapping from NUM_REQ-1 to 0, and returns a one-hot
//            grant (all-zero when nothing is requested).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ = SPR_NUM_REQ,
  parameter int ID_W    = SPR_ID_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic [NUM_REQ-1:0] w_rot_req;
  logic [NUM_REQ-1:0] w_rot_gnt;
  logic               w_found;

  // Rotate so that the pointer position becomes bit 0; a fixed lowest-first
  // priority on the rotated vector is then the round-robin search.
  assign w_rot_req = NUM_REQ'({req, req} >> rr_ptr);

  // Pick the lowest set bit of the rotated request vector.
  always_comb begin
    w_rot_gnt = '0;
    w_found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rot_req[k]) begin
        w_rot_gnt[k] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  // Rotate the grant back into requester numbering.
  assign gnt = NUM_REQ'({w_rot_gnt, w_rot_gnt} >> (32'(NUM_REQ) - 32'(rr_ptr)));

endmodule
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_rom_arbiter
// Purpose  : Shares one registered sprite ROM between NUM_REQ requesters.
//            Round-robin grant, ROM address mux, and a two-stage tag pipe
//            that tracks the ROM's two enabled-edge latency so each pixel is
//            returned with the index of the requester that asked for it.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ = SPR_NUM_REQ,
  parameter int X_W     = SPR_X_W,
  parameter int Y_W     = SPR_Y_W,
  parameter int COLOR_W = SPR_COLOR_W,
  parameter int ID_W    = SPR_ID_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_active,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*X_W-1:0] req_x,
  input  logic [NUM_REQ*Y_W-1:0] req_y,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   rom_en,
  output logic [X_W-1:0]         rom_x,
  output logic [Y_W-1:0]         rom_y,
  input  logic [COLOR_W-1:0]     rom_color,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [COLOR_W-1:0]     rsp_color
);

  logic [NUM_REQ-1:0] w_req_live;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [ID_W-1:0]    w_ptr_next;
  logic               w_accept;
  tag_t               w_s1_next;
  logic [ID_W-1:0]    r_rr_ptr;
  tag_t               r_s1;
  tag_t               r_s2;
  logic               r_s2_fresh;

  // No request can win while the frame is blanked or the block is in reset,
  // so masking here keeps gnt zero in both cases.
  assign w_req_live = (frame_active && rst_n) ? req : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req    (w_req_live),
    .rr_ptr (r_rr_ptr),
    .gnt    (gnt)
  );

  assign rom_en = frame_active;

  // gnt is a subset of live requests, so any grant bit is an acceptance.
  assign w_accept = |gnt;

  // Encode the one-hot grant and steer the winner's coordinates to the ROM.
  always_comb begin
    w_gnt_idx = '0;
    rom_x     = '0;
    rom_y     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        w_gnt_idx = ID_W'(i);
        rom_x     = req_x[i*X_W +: X_W];
        rom_y     = req_y[i*Y_W +: Y_W];
      end
    end
  end

  assign w_ptr_next = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
  assign w_s1_next  = '{valid: w_accept, id: SPR_ID_W'(w_gnt_idx)};

  // Round-robin pointer moves past the winner on each acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= w_ptr_next;
    end
  end

  // Tag pipe advances in lockstep with the ROM registers (enabled edges only);
  // r_s2_fresh marks the cycle right after stage 2 was reloaded so a held
  // tag is reported once, never repeated across blanked cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_s2_fresh <= 1'b0;
    end else begin
      r_s2_fresh <= frame_active;
      if (frame_active) begin
        r_s1 <= w_s1_next;
        r_s2 <= r_s1;
      end
    end
  end

  assign rsp_valid = r_s2.valid & r_s2_fresh;
  assign rsp_id    = ID_W'(r_s2.id);
  assign rsp_color = rom_color;

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_rom_arbiter
// Purpose  : Self-checking bench for sprite_rom_arbiter with a behavioural
//            two-register ROM and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_rom_arbiter;

  localparam int NR = 4;
  localparam int XW = 7;
  localparam int YW = 5;
  localparam int CW = 12;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            frame_active = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR*XW-1:0] req_x = '0;
  logic [NR*YW-1:0] req_y = '0;
  logic [NR-1:0]   gnt;
  logic            rom_en;
  logic [XW-1:0]   rom_x;
  logic [YW-1:0]   rom_y;
  logic [CW-1:0]   rom_color = '0;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [CW-1:0]   rsp_color;

  logic [XW+YW-1:0] rom_addr_q = '0;

  typedef struct {
    logic [IW-1:0] id;
    logic [CW-1:0] color;
    int            due;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   en_cnt = 0;
  bit   last_en = 1'b0;

  sprite_rom_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_active (frame_active),
    .req          (req),
    .req_x        (req_x),
    .req_y        (req_y),
    .gnt          (gnt),
    .rom_en       (rom_en),
    .rom_x        (rom_x),
    .rom_y        (rom_y),
    .rom_color    (rom_color),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_color    (rsp_color)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] rom_f(input logic [XW+YW-1:0] a);
    rom_f = (a * 12'd29) ^ 12'h3C5;
  endfunction

  function automatic logic [CW-1:0] exp_color(input int i);
    exp_color = rom_f({req_y[i*YW +: YW], req_x[i*XW +: XW]});
  endfunction

  // External ROM: address register then data register, both on rom_en.
  always @(posedge clk) begin
    if (rom_en) begin
      rom_addr_q <= {rom_y, rom_x};
      rom_color  <= rom_f(rom_addr_q);
    end
  end

  // Count enabled edges so each expected response knows when it is due.
  always @(posedge clk) begin
    last_en = frame_active;
    if (frame_active) en_cnt++;
  end

  // Scoreboard: compare the response strobe every cycle and pop on a pulse.
  always @(negedge clk) begin
    bit exp_v;
    exp_v = rst_n && last_en && (q.size() > 0) && (q[0].due == en_cnt);
    n_cmp++;
    if (rsp_valid !== exp_v) begin
      n_err++;
      $display("FAIL rsp_valid t=%0t got %b want %b", $time, rsp_valid, exp_v);
    end
    if (exp_v) begin
      if (rsp_valid === 1'b1) begin
        n_cmp++;
        if (rsp_id !== q[0].id || rsp_color !== q[0].color) begin
          n_err++;
          $display("FAIL rsp_data t=%0t got id=%0d color=%h want id=%0d color=%h",
                   $time, rsp_id, rsp_color, q[0].id, q[0].color);
        end
      end
      void'(q.pop_front());
    end
    if (!rst_n) q.delete();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_xy(input int i, input logic [XW-1:0] x, input logic [YW-1:0] y);
    req_x[i*XW +: XW] = x;
    req_y[i*YW +: YW] = y;
  endtask

  task automatic push_exp(input int i);
    q.push_back('{id: IW'(i), color: exp_color(i), due: en_cnt + 2});
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) break;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    q.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) set_xy(i, XW'(3 + i), YW'(2 + i));
    req = 4'b1111;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_err++; $display("FAIL reset_gnt got %b want 0000", gnt);
    end
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0) begin
      n_err++; $display("FAIL reset_rsp got v=%b id=%0d want v=0 id=0", rsp_valid, rsp_id);
    end
    n_cmp++;
    if (rom_en !== 1'b1 || rom_x !== 7'd0 || rom_y !== 5'd0) begin
      n_err++; $display("FAIL reset_rom got en=%b x=%0d y=%0d want en=1 x=0 y=0", rom_en, rom_x, rom_y);
    end
    tick();
    rst_n = 1'b1;
    req   = '0;
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] eg;
    int j;
    tick();
    for (int i = 0; i < NR; i++) set_xy(i, XW'(10 + 17 * i), YW'(1 + 7 * i));
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      j  = k % NR;
      eg = 4'b0001 << j;
      n_cmp++;
      if (gnt !== eg || rom_x !== req_x[j*XW +: XW] || rom_y !== req_y[j*YW +: YW]) begin
        n_err++;
        $display("FAIL rr_gnt k=%0d got gnt=%b x=%0d y=%0d want gnt=%b x=%0d y=%0d",
                 k, gnt, rom_x, rom_y, eg, req_x[j*XW +: XW], req_y[j*YW +: YW]);
      end
      push_exp(j);
    end
    tick();
    req = '0;
    drain();
  endtask

  task automatic test_single();
    tick();
    set_xy(0, 7'd5, 5'd3);
    req = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0001 || rom_x !== 7'd5 || rom_y !== 5'd3) begin
      n_err++;
      $display("FAIL single got gnt=%b x=%0d y=%0d want gnt=0001 x=5 y=3", gnt, rom_x, rom_y);
    end
    q.push_back('{id: 2'd0, color: rom_f({5'd3, 7'd5}), due: en_cnt + 2});
    tick();
    req = '0;
    drain();
  endtask

  task automatic test_frame_gap();
    tick();
    set_xy(1, 7'd100, 5'd20);
    req = 4'b0010;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_err++; $display("FAIL gap_gnt got %b want 0010", gnt);
    end
    push_exp(1);
    tick();
    req = '0;
    frame_active = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      n_cmp++;
      if (gnt !== 4'b0000 || rom_en !== 1'b0) begin
        n_err++; $display("FAIL gap_idle got gnt=%b en=%b want gnt=0000 en=0", gnt, rom_en);
      end
    end
    tick();
    frame_active = 1'b1;
    drain();
  endtask

  task automatic test_frame_off();
    tick();
    frame_active = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (gnt !== 4'b0000 || rom_en !== 1'b0) begin
        n_err++; $display("FAIL off_gnt got gnt=%b en=%b want gnt=0000 en=0", gnt, rom_en);
      end
      tick();
    end
    frame_active = 1'b1;
    req = '0;
    drain();
  endtask

  task automatic test_reset_mid();
    tick();
    set_xy(2, 7'd77, 5'd9);
    req = 4'b0100;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0100) begin
      n_err++; $display("FAIL mid_gnt got %b want 0100", gnt);
    end
    push_exp(2);
    tick();
    req   = '0;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_id !== 2'd0) begin
      n_err++; $display("FAIL mid_rst_id got %0d want 0", rsp_id);
    end
    tick();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tick();
    set_xy(0, 7'd42, 5'd17);
    req = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_err++; $display("FAIL mid_restart got %b want 0001", gnt);
    end
    push_exp(0);
    tick();
    req = '0;
    drain();
  endtask

  task automatic test_back_to_back_wrap();
    tick();
    set_xy(2, 7'd64, 5'd30);
    req = 4'b0100;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0100) begin
      n_err++; $display("FAIL wrap_pre got %b want 0100", gnt);
    end
    push_exp(2);
    tick();
    set_xy(0, 7'd1, 5'd2);
    set_xy(3, 7'd127, 5'd31);
    req = 4'b1001;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b1000 || rom_x !== 7'd127 || rom_y !== 5'd31) begin
      n_err++;
      $display("FAIL wrap_first got gnt=%b x=%0d y=%0d want gnt=1000 x=127 y=31", gnt, rom_x, rom_y);
    end
    push_exp(3);
    tick();
    req = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0001 || rom_x !== 7'd1) begin
      n_err++; $display("FAIL wrap_second got gnt=%b x=%0d want gnt=0001 x=1", gnt, rom_x);
    end
    push_exp(0);
    tick();
    req = '0;
    drain();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_frame_gap();
    test_frame_off();
    test_reset_mid();
    test_back_to_back_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
